// File: rtl/full_adder_unit.sv
// full_adder_unit: WIDTH-bit ripple adder built from one-bit full-adder
// cells, with carry-out, signed-overflow flag and an optional output
// register stage. WIDTH=1, REG_OUT=0 is a plain combinational full adder.

// One-bit full-adder cell: the leaf of the carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module full_adder_unit #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);
    // Output bundle, shared by the combinational and registered paths.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             overflow;
    } res_t;

    // Valid travels alongside the result; index STAGES is what leaves.
    localparam int STAGES = (REG_OUT != 0) ? 1 : 0;

    logic [WIDTH:0]   k;      // carry chain, k[0] is the carry-in
    logic [WIDTH-1:0] s;      // per-bit sums
    res_t             res_d;
    res_t             res_q;
    logic [STAGES:0]  vld_pipe;

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("full_adder_unit: WIDTH must be in 1..64");
    end

    assign k[0] = c;

    // Ripple chain: cell i consumes k[i] and produces k[i+1].
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (k[i]),
            .s  (s[i]),
            .co (k[i+1])
        );
    end

    // Signed overflow is the carry into the MSB differing from the carry out;
    // at WIDTH=1 the carry into the MSB is the carry-in itself.
    assign res_d.sum      = s;
    assign res_d.carry    = k[WIDTH];
    assign res_d.overflow = k[WIDTH] ^ k[WIDTH-1];

    // in_valid never gates the arithmetic, it only qualifies the result.
    assign vld_pipe[0] = in_valid;

    if (REG_OUT != 0) begin : g_reg
        // Capture every cycle; reset clears the in-flight result outright.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                res_q       <= '0;
                vld_pipe[1] <= 1'b0;
            end else begin
                res_q       <= res_d;
                vld_pipe[1] <= vld_pipe[0];
            end
        end
    end else begin : g_comb
        // No state: clock and reset are intentionally left unused here.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst};
        assign res_q          = res_d;
    end

    assign sum       = res_q.sum;
    assign carry     = res_q.carry;
    assign overflow  = res_q.overflow;
    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_full_adder_unit.sv
// Scoreboard bench for full_adder_unit: five instances cover the WIDTH=1
// leaf, 8-bit combinational and registered variants, and 16-bit random
// traffic in both output modes. Expected results are queued at stimulus
// time and popped by a negedge monitor whenever an instance asserts out_valid.
module tb_full_adder_unit;
    typedef struct {
        logic [15:0] s;
        logic        k;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst16 = 1'b1;
    logic rst_na = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=1 combinational
    logic       a_1 = 0, b_1 = 0, ci_1 = 0, iv_1 = 0;
    logic       sum_1, co_1, ovf_1, ov_1;
    // Instance 1: WIDTH=8 combinational, instance 2: WIDTH=8 registered
    logic [7:0] a_8 = 0, b_8 = 0;
    logic       ci_8 = 0, iv_8 = 0;
    logic [7:0] sum_8, sum_8r;
    logic       co_8, ovf_8, ov_8, co_8r, ovf_8r, ov_8r;
    logic [7:0] a_8r = 0, b_8r = 0;
    logic       ci_8r = 0, iv_8r = 0;
    // Instances 3/4: WIDTH=16 combinational / registered, shared inputs
    logic [15:0] a_16 = 0, b_16 = 0;
    logic        ci_16 = 0, iv_16 = 0;
    logic [15:0] sum_16, sum_16r;
    logic        co_16, ovf_16, ov_16, co_16r, ovf_16r, ov_16r;

    full_adder_unit #(.WIDTH(1), .REG_OUT(0)) u_w1 (
        .clk(clk), .rst(rst_na), .a(a_1), .b(b_1), .c(ci_1), .in_valid(iv_1),
        .sum(sum_1), .carry(co_1), .overflow(ovf_1), .out_valid(ov_1));
    full_adder_unit #(.WIDTH(8), .REG_OUT(0)) u_w8 (
        .clk(clk), .rst(rst_na), .a(a_8), .b(b_8), .c(ci_8), .in_valid(iv_8),
        .sum(sum_8), .carry(co_8), .overflow(ovf_8), .out_valid(ov_8));
    full_adder_unit #(.WIDTH(8), .REG_OUT(1)) u_w8r (
        .clk(clk), .rst(rst8), .a(a_8r), .b(b_8r), .c(ci_8r), .in_valid(iv_8r),
        .sum(sum_8r), .carry(co_8r), .overflow(ovf_8r), .out_valid(ov_8r));
    full_adder_unit #(.WIDTH(16), .REG_OUT(0)) u_w16 (
        .clk(clk), .rst(rst_na), .a(a_16), .b(b_16), .c(ci_16), .in_valid(iv_16),
        .sum(sum_16), .carry(co_16), .overflow(ovf_16), .out_valid(ov_16));
    full_adder_unit #(.WIDTH(16), .REG_OUT(1)) u_w16r (
        .clk(clk), .rst(rst16), .a(a_16), .b(b_16), .c(ci_16), .in_valid(iv_16),
        .sum(sum_16r), .carry(co_16r), .overflow(ovf_16r), .out_valid(ov_16r));

    exp_t q [5][$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic sb8r_en = 1'b1;

    // WIDTH=1 truth table, index = {a,b,c}
    logic [7:0] t1_s = 8'b1001_0110;  // bit i = sum for index i
    logic [7:0] t1_k = 8'b1110_1000;
    logic [7:0] t1_v = 8'b0100_0010;

    // 8-bit directed vectors with hand-computed results
    logic [7:0] t8_a [8] = '{8'hFF, 8'h3C, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] t8_b [8] = '{8'h01, 8'h42, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00};
    logic       t8_c [8] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
    logic [7:0] t8_s [8] = '{8'h00, 8'h7F, 8'h80, 8'h7F, 8'h01, 8'hFF, 8'h00, 8'h00};
    logic       t8_k [8] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
    logic       t8_v [8] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};

    // Packed as {valid, sum, carry, overflow}.
    task automatic cmp(input string nm, input logic [18:0] got, input logic [18:0] req);
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got v/s/k/o=%h required %h at %0t", nm, got, req, $time);
        end
    endtask

    task automatic pop_chk(input int id, input string nm, input logic [15:0] s,
                           input logic k, input logic o);
        exp_t e;
        if (q[id].size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s unexpected out_valid: got 1 required 0 at %0t", nm, $time);
        end else begin
            e = q[id].pop_front();
            cmp(nm, {1'b1, s, k, o}, {1'b1, e.s, e.k, e.v});
        end
    endtask

    task automatic monitor_step();
        if (ov_1)              pop_chk(0, "w1",   {15'd0, sum_1}, co_1, ovf_1);
        if (ov_8)              pop_chk(1, "w8",   {8'd0, sum_8}, co_8, ovf_8);
        if (ov_8r && sb8r_en)  pop_chk(2, "w8r",  {8'd0, sum_8r}, co_8r, ovf_8r);
        if (ov_16)             pop_chk(3, "w16",  sum_16, co_16, ovf_16);
        if (ov_16r)            pop_chk(4, "w16r", sum_16r, co_16r, ovf_16r);
    endtask

    task automatic push(input int id, input logic [15:0] s, input logic k, input logic v);
        exp_t e;
        e.s = s;
        e.k = k;
        e.v = v;
        q[id].push_back(e);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] st8r();
        return {ov_8r, 8'd0, sum_8r, co_8r, ovf_8r};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [16:0] t;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset state of the registered instances
        #3;
        cmp("rst8 state",  st8r(), 19'd0);
        cmp("rst16 state", {ov_16r, sum_16r, co_16r, ovf_16r}, 19'd0);
        #9;
        rst8  = 1'b0;
        rst16 = 1'b0;

        // WIDTH=1 exhaustive truth table
        for (int i = 0; i < 8; i++) begin
            drive_edge();
            {a_1, b_1, ci_1} = 3'(i);
            iv_1 = 1'b1;
            push(0, {15'd0, t1_s[i]}, t1_k[i], t1_v[i]);
        end
        drive_edge();
        iv_1 = 1'b0;

        // 8-bit directed vectors, combinational and registered
        for (int i = 0; i < 8; i++) begin
            drive_edge();
            a_8 = t8_a[i]; b_8 = t8_b[i]; ci_8 = t8_c[i]; iv_8 = 1'b1;
            a_8r = t8_a[i]; b_8r = t8_b[i]; ci_8r = t8_c[i]; iv_8r = 1'b1;
            push(1, {8'd0, t8_s[i]}, t8_k[i], t8_v[i]);
            push(2, {8'd0, t8_s[i]}, t8_k[i], t8_v[i]);
        end
        drive_edge();
        iv_8  = 1'b0;
        iv_8r = 1'b0;
        repeat (3) drive_edge();

        // Registered latency: nothing moves until edge N, result after it
        sb8r_en = 1'b0;
        a_8r = 8'h10; b_8r = 8'h20; ci_8r = 1'b1; iv_8r = 1'b1;
        @(negedge clk);
        cmp("lat before edge", st8r(), 19'd0);
        drive_edge();
        cmp("lat after edge", st8r(), {1'b1, 16'h0031, 1'b0, 1'b0});
        iv_8r = 1'b0;
        drive_edge();
        cmp("lat valid drop", st8r(), {1'b0, 16'h0031, 1'b0, 1'b0});

        // Asynchronous reset mid-cycle, then release between edges
        iv_8r = 1'b1;
        drive_edge();
        cmp("pre-reset", st8r(), {1'b1, 16'h0031, 1'b0, 1'b0});
        #2;
        rst8 = 1'b1;
        #1;
        cmp("async reset", st8r(), 19'd0);
        drive_edge();
        cmp("reset hold edge", st8r(), 19'd0);
        #2;
        rst8 = 1'b0;
        #1;
        cmp("reset release", st8r(), 19'd0);
        drive_edge();
        cmp("first after reset", st8r(), {1'b1, 16'h0031, 1'b0, 1'b0});
        iv_8r = 1'b0;
        drive_edge();
        sb8r_en = 1'b1;

        // 16-bit random traffic through both output modes
        for (int i = 0; i < 10000; i++) begin
            drive_edge();
            a_16  = 16'($urandom);
            b_16  = 16'($urandom);
            ci_16 = 1'($urandom);
            iv_16 = 1'b1;
            t = {1'b0, a_16} + {1'b0, b_16} + {16'd0, ci_16};
            push(3, t[15:0], t[16], (a_16[15] == b_16[15]) && (t[15] != a_16[15]));
            push(4, t[15:0], t[16], (a_16[15] == b_16[15]) && (t[15] != a_16[15]));
        end
        drive_edge();
        iv_16 = 1'b0;
        repeat (3) drive_edge();

        // Every queued result must have been presented
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (q[i].size() != 0) begin
                n_miss++;
                $display("FAIL drain q%0d: got %0d pending required 0", i, q[i].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
